// File: rtl/minmax_seq.sv
// ---------------------------------------------------------------------------
// minmax_seq
//   Tracks the minimum and maximum of a burst of unsigned 2-bit samples.
//   The first sample of a burst loads both min and max directly. Every later
//   sample goes through two compare cycles that share a single comparator mux:
//   first against the running minimum, then against the running maximum.
//
// Ports
//   clk          single clock, rising-edge
//   reset        asynchronous, active-high
//   in_start     start-of-burst request (sampled only when idle)
//   in_len       burst length, 0 treated as 1 (sampled with in_start)
//   in_valid     qualifies in_data
//   in_data      2-bit unsigned sample
//   out_ready    sample is accepted this cycle when in_valid is high
//   out_busy     a burst is in progress
//   out_cmp_sel  shared comparator mux select (0 = less-than, 1 = greater-than)
//   out_min      running / final minimum
//   out_max      running / final maximum
//   out_done     one-cycle pulse when the result is final
// ---------------------------------------------------------------------------

// 2-bit strict less-than: lt = (a < b)
module minmax_lt2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt
);
    assign lt = (a < b);
endmodule

// 2-bit strict greater-than: gt = (a > b)
module minmax_gt2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);
    assign gt = (a > b);
endmodule

// 1-bit 2:1 mux: y = sel ? d1 : d0
module minmax_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// ---------------------------------------------------------------------------
// state     | meaning
// ----------+----------------------------------------------------------------
// S_IDLE    | waiting for in_start; latches burst length
// S_FIRST   | ready for the first sample; loads min and max directly
// S_WAIT    | ready for a later sample; latches it as candidate
// S_CMP_MIN | mux selects less-than; candidate replaces min if smaller
// S_CMP_MAX | mux selects greater-than; candidate replaces max if larger
// S_DONE    | one-cycle done pulse, then back to idle
// ---------------------------------------------------------------------------
module minmax_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_start,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_valid,
    input  logic [1:0]       in_data,
    output logic             out_ready,
    output logic             out_busy,
    output logic             out_cmp_sel,
    output logic [1:0]       out_min,
    output logic [1:0]       out_max,
    output logic             out_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FIRST   = 3'd1,
        S_WAIT    = 3'd2,
        S_CMP_MIN = 3'd3,
        S_CMP_MAX = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       min_q, min_d;
    logic [1:0]       max_q, max_d;

    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_sel;
    logic             cmp_hit;

    // Shared compare datapath: candidate is always operand A; the mux output
    // is the only signal allowed to drive min/max replacement.
    minmax_lt2 u_lt (
        .a  (cand_q),
        .b  (min_q),
        .lt (cmp_lt)
    );

    minmax_gt2 u_gt (
        .a  (cand_q),
        .b  (max_q),
        .gt (cmp_gt)
    );

    minmax_mux2 u_mux (
        .sel (cmp_sel),
        .d0  (cmp_lt),
        .d1  (cmp_gt),
        .y   (cmp_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cand_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cand_q      <= cand_d;
            min_q       <= min_d;
            max_q       <= max_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cand_d      = cand_q;
        min_d       = min_q;
        max_d       = max_q;
        out_ready   = 1'b0;
        out_busy    = 1'b1;
        cmp_sel     = 1'b0;
        out_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_busy = 1'b0;
                if (in_start) begin
                    // A zero length still produces a one-sample burst.
                    remaining_d = (in_len == '0) ? LEN_W'(1) : in_len;
                    state_d     = S_FIRST;
                end
            end

            S_FIRST: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    min_d       = in_data;
                    max_d       = in_data;
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_WAIT;
                end
            end

            S_WAIT: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    cand_d  = in_data;
                    state_d = S_CMP_MIN;
                end
            end

            S_CMP_MIN: begin
                cmp_sel = 1'b0;
                if (cmp_hit) begin
                    min_d = cand_q;
                end
                state_d = S_CMP_MAX;
            end

            S_CMP_MAX: begin
                cmp_sel = 1'b1;
                if (cmp_hit) begin
                    max_d = cand_q;
                end
                remaining_d = remaining_q - LEN_W'(1);
                state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_WAIT;
            end

            S_DONE: begin
                out_done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                out_busy = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign out_cmp_sel = cmp_sel;
    assign out_min     = min_q;
    assign out_max     = max_q;

endmodule

// File: tb/tb_minmax_seq.sv
// ---------------------------------------------------------------------------
// tb_minmax_seq
//   Self-checking bench for minmax_seq. A transaction-level model tracks how
//   many samples a burst still needs, how many compare cycles remain after a
//   sample, and the min/max of the accepted samples using plain arithmetic.
//   One negedge process compares the DUT against it every cycle; directed
//   scenarios add literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_minmax_seq;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_start;
    logic [LEN_W-1:0] in_len;
    logic             in_valid;
    logic [1:0]       in_data;
    logic             out_ready;
    logic             out_busy;
    logic             out_cmp_sel;
    logic [1:0]       out_min;
    logic [1:0]       out_max;
    logic             out_done;

    int n_cmp = 0;
    int n_err = 0;

    minmax_seq #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_start    (in_start),
        .in_len      (in_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .out_busy    (out_busy),
        .out_cmp_sel (out_cmp_sel),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_done    (out_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc     = 0;
    bit m_busy  = 0;
    bit m_first = 0;
    bit m_done  = 0;
    int m_need  = 0;   // samples still to be accepted
    int m_cool  = 0;   // compare cycles left after a non-first sample
    int m_min   = 0;
    int m_max   = 0;
    int acc_q[$];      // cycle index of each accepted sample
    int done_q[$];     // cycle index of each done pulse

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 0;
            m_first <= 0;
            m_done  <= 0;
            m_need  <= 0;
            m_cool  <= 0;
            m_min   <= 0;
            m_max   <= 0;
        end else begin : step
            bit busy, first, done;
            int need, cool, mn, mx, d;
            busy = m_busy; first = m_first; done = m_done;
            need = m_need; cool = m_cool; mn = m_min; mx = m_max;
            d = int'(in_data);
            if (done) begin
                done = 0;
                busy = 0;
            end else if (!busy) begin
                if (in_start) begin
                    busy  = 1;
                    first = 1;
                    need  = (in_len == 0) ? 1 : int'(in_len);
                end
            end else if (cool > 0) begin
                cool--;
                if (cool == 0 && need == 0) done = 1;
            end else if (in_valid) begin
                acc_q.push_back(cyc);
                need--;
                if (first) begin
                    first = 0;
                    mn = d;
                    mx = d;
                    if (need == 0) done = 1;
                end else begin
                    cool = 2;
                    if (d < mn) mn = d;
                    if (d > mx) mx = d;
                end
            end
            m_busy  <= busy;
            m_first <= first;
            m_done  <= done;
            m_need  <= need;
            m_cool  <= cool;
            m_min   <= mn;
            m_max   <= mx;
            cyc     <= cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", out_busy, m_busy);
        chk("ready", out_ready, (m_busy && !m_done && m_cool == 0));
        chk("cmp_sel", out_cmp_sel, (m_cool == 1));
        chk("done", out_done, m_done);
        if (m_cool == 0) begin
            chk("min", out_min, m_min);
            chk("max", out_max, m_max);
        end
        if (out_done) done_q.push_back(cyc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_burst(input int len);
        tick();
        in_start = 1'b1;
        in_len   = LEN_W'(len);
        tick();
        in_start = 1'b0;
    endtask

    task automatic send(input int d, input bit hold);
        int n = 0;
        while (!out_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", out_ready, 1);
        in_data  = 2'(d);
        in_valid = 1'b1;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!out_done && n < 100) begin
            tick();
            n++;
        end
        chk("done_wait", out_done, 1);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic clear_logs();
        acc_q.delete();
        done_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc;
        reset    = 1'b1;
        in_start = 1'b0;
        in_len   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        chk("rst_busy", out_busy, 0);
        chk("rst_ready", out_ready, 0);
        chk("rst_done", out_done, 0);
        chk("rst_min", out_min, 0);
        chk("rst_max", out_max, 0);
        reset = 1'b0;
        tick();

        // len=4, samples 2,0,3,1 with valid held high
        clear_logs();
        start_burst(4);
        send(2, 1);
        send(0, 1);
        send(3, 1);
        send(1, 0);
        wait_done();
        chk("b4_min", out_min, 0);
        chk("b4_max", out_max, 3);
        chk("b4_done_cnt", done_q.size(), 1);
        chk("b4_acc_cnt", acc_q.size(), 4);
        if (acc_q.size() == 4 && done_q.size() == 1) begin
            chk("b4_gap1", acc_q[1] - acc_q[0], 1);
            chk("b4_gap2", acc_q[2] - acc_q[1], 3);
            chk("b4_gap3", acc_q[3] - acc_q[2], 3);
            chk("b4_latency", done_q[0] - acc_q[3], 3);
        end

        // len=1 and len=0, sample 2
        for (int l = 1; l >= 0; l--) begin
            clear_logs();
            start_burst(l);
            send(2, 0);
            wait_done();
            chk("b1_min", out_min, 2);
            chk("b1_max", out_max, 2);
            chk("b1_done_cnt", done_q.size(), 1);
            if (acc_q.size() == 1 && done_q.size() == 1)
                chk("b1_latency", done_q[0] - acc_q[0], 1);
        end

        // len=3, equal samples
        clear_logs();
        start_burst(3);
        send(1, 0);
        send(1, 0);
        send(1, 0);
        wait_done();
        chk("eq_min", out_min, 1);
        chk("eq_max", out_max, 1);

        // len=3 with a long valid gap and a stray start while busy
        clear_logs();
        start_burst(3);
        send(2, 0);
        for (int i = 0; i < 5; i++) begin
            in_start = (i == 2);
            in_len   = 4'd7;
            tick();
            chk("gap_busy", out_busy, 1);
            chk("gap_ready", out_ready, 1);
        end
        in_start = 1'b0;
        send(1, 0);
        send(3, 0);
        wait_done();
        chk("gap_min", out_min, 1);
        chk("gap_max", out_max, 3);
        chk("gap_acc_cnt", acc_q.size(), 3);
        chk("gap_done_cnt", done_q.size(), 1);

        // reset in CMP_MAX of a len=4 burst, then a len=2 burst
        clear_logs();
        start_burst(4);
        send(1, 1);
        send(2, 0);
        begin
            int n = 0;
            while (!out_cmp_sel && n < 10) begin
                tick();
                n++;
            end
        end
        chk("pre_rst_sel", out_cmp_sel, 1);
        dc = done_q.size();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", out_busy, 0);
        chk("mid_rst_ready", out_ready, 0);
        chk("mid_rst_sel", out_cmp_sel, 0);
        chk("mid_rst_done", out_done, 0);
        chk("mid_rst_min", out_min, 0);
        chk("mid_rst_max", out_max, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("mid_rst_nodone", done_q.size(), dc);
        start_burst(2);
        send(3, 0);
        send(0, 0);
        wait_done();
        chk("post_rst_min", out_min, 0);
        chk("post_rst_max", out_max, 3);

        // randomized traffic, including occasional resets
        dc = done_q.size();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            in_start = ($urandom_range(0, 5) == 0);
            in_len   = LEN_W'($urandom);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 2'($urandom);
        end
        reset    = 1'b0;
        in_start = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rand_bursts", (done_q.size() - dc) > 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
